uart_tx_arbiter: RTL and testbench

Shares the single terminal UART TX line (115200 8N1, GPIO-routed beside the RX on bit 16) between NUM_REQ byte-stream requesters.
- Round-robin arbitration with packet lock, so a multi-byte message (e.g. "ABC\r\n") is never interleaved with another requester's bytes.
- Contains the bit-timing serializer that drives the line.
- Sits in the SoC demo top between on-chip debug/status producers and the GPIO output mux.

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_tx_serializer.sv | 104 ++++++++++
 rtl/uart_tx_arbiter.sv | 91 +++++++++
 tb/tb_uart_tx_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter and its serializer.
// Provides the serializer state encoding and the baud-divider calculation.
package uart_arb_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_e;

  // Integer truncation is intended: the line tolerates the small rate error.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 bit-timing serializer: START, eight data bits LSB first, STOP.
// The line output is registered and is forced high by reset.
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 uart_tx,
  output logic                 idle
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

  ser_state_e           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        if (start) begin
          state_d = START;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[idx_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;
  assign idle    = (state_q == IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with packet lock sharing one UART TX line between
// NUM_REQ byte-stream requesters; the serializer drives the line.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLK_FREQ_HZ  = 27_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);

  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        cand;
  logic                 cand_found;
  logic                 idle;
  logic                 accept;
  logic [DATA_BITS-1:0] sel_data;

  // A held lock pins the candidate to the owner even when it drops valid,
  // which is what keeps a packet from being interleaved.
  always_comb begin
    int idx;
    idx        = 0;
    cand       = grant_id;
    cand_found = 1'b0;
    if (locked) begin
      cand_found = req_valid[grant_id];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!cand_found && req_valid[idx]) begin
          cand       = IW'(idx);
          cand_found = 1'b1;
        end
      end
    end
  end

  assign accept   = idle && !rst && cand_found;
  assign sel_data = req_data[8*int'(cand) +: 8];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[cand] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_id <= '0;
      locked   <= 1'b0;
      rr_ptr   <= '0;
    end else if (accept) begin
      grant_id <= cand;
      if (req_last[cand]) begin
        locked <= 1'b0;
        rr_ptr <= (cand == PTR_LAST) ? '0 : cand + 1'b1;
      end else begin
        locked <= 1'b1;
      end
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .data   (sel_data),
    .uart_tx(uart_tx),
    .idle   (idle)
  );

  assign busy = !idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: framing, packet lock, round-robin order,
// indefinite lock stall, mid-frame reset and a short-bit-time instance.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;

  logic [NR-1:0] ready_b, ready_s;
  logic          tx_b, tx_s, busy_b, busy_s, locked_b, locked_s;
  logic [1:0]    grant_b, grant_s;

  logic use_small = 1'b0;
  int   cpb = 234;
  int   n_cmp = 0;
  int   n_err = 0;

  wire [NR-1:0] ready_m = use_small ? ready_s : ready_b;
  wire          line    = use_small ? tx_s : tx_b;
  wire          busy_m  = use_small ? busy_s : busy_b;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_b), .uart_tx(tx_b), .busy(busy_b),
    .grant_id(grant_b), .locked(locked_b)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .CLKS_PER_BIT(2)) dut_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(ready_s), .uart_tx(tx_s), .busy(busy_s),
    .grant_id(grant_s), .locked(locked_s)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[8*i +: 8] = d;
    req_last[i]        = l;
  endtask

  // Waits (bounded) at negedges until requester i is offered ready.
  task automatic wait_accept(input int i, input int budget, input string tag);
    int w;
    w = 0;
    #1;
    while (!ready_m[i] && w < budget) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_wait"}, w, 0);
    check({tag, "_onehot"}, 32'(ready_m), 32'(1) << i);
  endtask

  // Called at the negedge of the first start-bit cycle; returns at the
  // negedge of the first idle cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input string tag);
    int cur;
    int t;
    logic e;
    cur = 0;
    check({tag, "_busy0"}, busy_m, 1);
    for (int k = 0; k < 10; k++) begin
      t = k * cpb + cpb / 2;
      repeat (t - cur) @(negedge clk);
      cur = t;
      if (k == 0) e = 1'b0;
      else if (k == 9) e = 1'b1;
      else e = b[k-1];
      check($sformatf("%s_bit%0d", tag, k), line, e);
      if (k == 0) check({tag, "_rdy_in_frame"}, 32'(ready_m), 0);
    end
    repeat (10 * cpb - 1 - cur) @(negedge clk);
    check({tag, "_busy_last"}, busy_m, 1);
    @(negedge clk);
    check({tag, "_busy_end"}, busy_m, 0);
    check({tag, "_line_idle"}, line, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msg [5];
    int bad;
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'h0D; msg[4] = 8'h0A;

    // Reset state, with a requester already valid.
    set_req(0, 1'b1, 8'h41, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_tx", tx_b, 1);
    check("rst_busy", busy_b, 0);
    check("rst_ready", 32'(ready_b), 0);
    check("rst_grant", 32'(grant_b), 0);
    check("rst_locked", locked_b, 0);

    // Single byte 0x41.
    rst = 1'b0;
    wait_accept(0, 10, "t1");
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 1'b0);
    check("t1_grant", 32'(grant_b), 0);
    check("t1_locked", locked_b, 0);
    check_frame(8'h41, "t1");

    // Packet "ABC\r\n" from req1 while req2 waits.
    set_req(2, 1'b1, 8'h5A, 1'b1);
    set_req(1, 1'b1, msg[0], 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) set_req(1, 1'b1, msg[4], 1'b1);
      wait_accept(1, 10, $sformatf("t2_b%0d", k));
      check($sformatf("t2_lock_pre%0d", k), locked_b, (k != 0));
      @(negedge clk);
      if (k < 3) set_req(1, 1'b1, msg[k+1], 1'b0);
      else if (k == 3) set_req(1, 1'b1, msg[4], 1'b1);
      else set_req(1, 1'b0, 8'h00, 1'b0);
      check($sformatf("t2_lock_post%0d", k), locked_b, (k != 4));
      check($sformatf("t2_grant%0d", k), 32'(grant_b), 1);
      check_frame(msg[k], $sformatf("t2_f%0d", k));
    end
    wait_accept(2, 10, "t2_req2");
    @(negedge clk);
    set_req(2, 1'b0, 8'h00, 1'b0);
    check_frame(8'h5A, "t2_req2");

    // All four valid from rr_ptr=0: order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
    for (int s = 0; s < 5; s++) begin
      wait_accept(s % NR, 10, $sformatf("t3_s%0d", s));
      @(negedge clk);
      if (s == 4) req_valid = '0;
      check($sformatf("t3_grant%0d", s), 32'(grant_b), 32'(s % NR));
      check_frame(8'(8'h10 + s % NR), $sformatf("t3_f%0d", s));
    end

    // Lock stall: rr_ptr=1, req3 wins ahead of req0, then goes silent.
    set_req(0, 1'b1, 8'h44, 1'b1);
    set_req(3, 1'b1, 8'h33, 1'b0);
    wait_accept(3, 10, "t4_a");
    @(negedge clk);
    set_req(3, 1'b0, 8'h00, 1'b0);
    check_frame(8'h33, "t4_a");
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      if (tx_b !== 1'b1 || ready_b !== '0 || locked_b !== 1'b1) bad++;
      @(negedge clk);
    end
    check("t4_stall_bad_cycles", bad, 0);
    set_req(3, 1'b1, 8'h0D, 1'b1);
    wait_accept(3, 10, "t4_b");
    @(negedge clk);
    set_req(3, 1'b0, 8'h00, 1'b0);
    check_frame(8'h0D, "t4_b");
    wait_accept(0, 10, "t4_c");
    @(negedge clk);
    set_req(0, 1'b0, 8'h00, 1'b0);
    check_frame(8'h44, "t4_c");

    // Reset mid-DATA of a 0x55 frame from req2 (lock held, grant_id=2).
    set_req(2, 1'b1, 8'h55, 1'b0);
    wait_accept(2, 10, "t5_a");
    @(negedge clk);
    set_req(2, 1'b0, 8'h00, 1'b0);
    repeat (600) @(negedge clk);
    check("t5_pre_line", tx_b, 0);
    check("t5_pre_locked", locked_b, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_line", tx_b, 1);
    check("t5_rst_busy", busy_b, 0);
    check("t5_rst_locked", locked_b, 0);
    check("t5_rst_grant", 32'(grant_b), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_req(1, 1'b1, 8'h81, 1'b1);
    wait_accept(1, 10, "t5_b");
    @(negedge clk);
    set_req(1, 1'b0, 8'h00, 1'b0);
    check_frame(8'h81, "t5_b");

    // Two clocks per bit, 0xFF, valid held so ready returns on cycle 21.
    do_reset();
    use_small = 1'b1;
    cpb = 2;
    set_req(0, 1'b1, 8'hFF, 1'b1);
    wait_accept(0, 10, "t6_a");
    @(negedge clk);
    check_frame(8'hFF, "t6");
    check("t6_ready_back", 32'(ready_m), 1);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
